// File: rtl/controle_cronometro_posse.sv
// Referee-button front end for the 14/24 s shot clock: debounces the buttons, applies the
// reload rules, and latches a violation when the countdown buzzer fires while running.
module controle_cronometro_posse #(
  parameter int DB_CYCLES = 50000
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       btn_posse,
  input  logic       btn_rebote,
  input  logic       btn_falta,
  input  logic       btn_pausa,
  input  logic       game_stop,
  input  logic [4:0] shot_value,
  input  logic       shot_buzzer,
  output logic       resetNumero,
  output logic       chaveParar,
  output logic       chaveEscolherCronometro,
  output logic       violacao,
  output logic [1:0] estado
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    STOPPED = 2'b00,
    RUNNING = 2'b01,
    EXPIRED = 2'b10
  } state_t;

  // Bit order everywhere: 3 posse, 2 falta, 1 rebote, 0 pausa.
  logic [3:0] raw, sync1, sync2, level, level_prev, event_pulse;
  logic       ev_posse, ev_falta, ev_rebote, ev_pausa;
  logic       loaded;
  state_t     state, state_next;
  logic       pulse_next, chave_next, load24, load14;

  assign raw = {btn_posse, btn_falta, btn_rebote, btn_pausa};

  // Synchronizers and registered rising-edge detection of the debounced levels
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync1       <= 4'b0000;
      sync2       <= 4'b0000;
      level_prev  <= 4'b0000;
      event_pulse <= 4'b0000;
    end else begin
      sync1       <= raw;
      sync2       <= sync1;
      level_prev  <= level;
      event_pulse <= level & ~level_prev;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic          lvl;

    // Level follows the synchronized input only after DB_CYCLES consecutive mismatches
    always_ff @(posedge clock_in or posedge reset) begin
      if (reset) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] != lvl) begin
        if (cnt == CNT_LAST) begin
          lvl <= sync2[i];
          cnt <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end

    assign level[i] = lvl;
  end

  assign ev_posse  = event_pulse[3];
  assign ev_falta  = event_pulse[2];
  assign ev_rebote = event_pulse[1];
  assign ev_pausa  = event_pulse[0];

  // Next-state and reload decision; only the highest-priority event is acted on
  always_comb begin
    state_next = state;
    load24     = 1'b0;
    load14     = 1'b0;
    pulse_next = 1'b0;
    chave_next = chaveEscolherCronometro;
    if (!loaded) begin
      load24 = 1'b1;
    end else begin
      case (state)
        STOPPED: begin
          if (ev_posse) begin
            load24 = 1'b1;
          end else if (ev_falta || ev_rebote) begin
            load14 = 1'b1;
          end else if (ev_pausa && !game_stop) begin
            state_next = RUNNING;
          end else begin
            state_next = STOPPED;
          end
        end
        RUNNING: begin
          if (shot_buzzer && !ev_posse) begin
            state_next = EXPIRED;
          end else if (ev_posse) begin
            load24 = 1'b1;
          end else if (ev_falta) begin
            load14     = 1'b1;
            state_next = STOPPED;
          end else if (ev_rebote) begin
            load14 = 1'b1;
          end else if (ev_pausa || game_stop) begin
            state_next = STOPPED;
          end else begin
            state_next = RUNNING;
          end
        end
        EXPIRED: begin
          if (ev_posse) begin
            load24     = 1'b1;
            state_next = STOPPED;
          end else begin
            state_next = EXPIRED;
          end
        end
        default: begin
          state_next = STOPPED;
        end
      endcase
    end
    // A 14 s reload never raises the clock: at 14 or above it is a no-op.
    if (load24) begin
      pulse_next = 1'b1;
      chave_next = 1'b1;
    end else if (load14 && (shot_value < 5'd14)) begin
      pulse_next = 1'b1;
      chave_next = 1'b0;
    end else begin
      pulse_next = 1'b0;
      chave_next = chaveEscolherCronometro;
    end
  end

  // State and registered countdown controls
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state                   <= STOPPED;
      loaded                  <= 1'b0;
      resetNumero             <= 1'b0;
      chaveParar              <= 1'b1;
      chaveEscolherCronometro <= 1'b1;
      violacao                <= 1'b0;
    end else begin
      state                   <= state_next;
      loaded                  <= 1'b1;
      resetNumero             <= pulse_next;
      chaveParar              <= (state_next != RUNNING);
      chaveEscolherCronometro <= chave_next;
      violacao                <= (state_next == EXPIRED);
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_controle_cronometro_posse.sv
// Bench for controle_cronometro_posse: table of button/level vectors through a scoreboard
// queue, plus hand-written sequences for latency, glitch, same-cycle and reset corners.
module tb_controle_cronometro_posse;
  logic       clock_in = 1'b0;
  logic       reset = 1'b1;
  logic       btn_posse = 1'b0, btn_rebote = 1'b0, btn_falta = 1'b0, btn_pausa = 1'b0;
  logic       game_stop = 1'b0;
  logic [4:0] shot_value = 5'd20;
  logic       shot_buzzer = 1'b0;
  logic       resetNumero, chaveParar, chaveEscolherCronometro, violacao;
  logic [1:0] estado;

  always #5 clock_in = ~clock_in;

  controle_cronometro_posse #(.DB_CYCLES(4)) dut (
    .clock_in(clock_in), .reset(reset),
    .btn_posse(btn_posse), .btn_rebote(btn_rebote), .btn_falta(btn_falta), .btn_pausa(btn_pausa),
    .game_stop(game_stop), .shot_value(shot_value), .shot_buzzer(shot_buzzer),
    .resetNumero(resetNumero), .chaveParar(chaveParar),
    .chaveEscolherCronometro(chaveEscolherCronometro), .violacao(violacao), .estado(estado)
  );

  // Output word: {resetNumero, chaveParar, chave, violacao, estado[1:0]}
  typedef struct {
    string      name;
    logic [3:0] btn;   // {posse, falta, rebote, pausa}
    logic [4:0] shot;
    logic       gstop;
    logic       buzz;
    int         edges;
    logic [5:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t       vecs [NV];
  logic [5:0] sb_exp_q[$];
  string      sb_name_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pulses;

  function automatic vec_t mk(string n, logic [3:0] b, logic [4:0] s, logic g, logic z,
                              int e, logic [5:0] x);
    vec_t v;
    v.name = n; v.btn = b; v.shot = s; v.gstop = g; v.buzz = z; v.edges = e; v.exp = x;
    return v;
  endfunction

  function automatic logic [5:0] outs();
    return {resetNumero, chaveParar, chaveEscolherCronometro, violacao, estado};
  endfunction

  task automatic check(input string nm, input logic [5:0] exp);
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (pulse,parar,chave,viol,estado)", nm, outs(), exp);
    end
  endtask

  task automatic expect_push(input string nm, input logic [5:0] exp);
    sb_name_q.push_back(nm);
    sb_exp_q.push_back(exp);
  endtask

  task automatic check_pop();
    if (sb_exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      check(sb_name_q.pop_front(), sb_exp_q.pop_front());
    end
  endtask

  task automatic drive_btn(input logic [3:0] b);
    {btn_posse, btn_falta, btn_rebote, btn_pausa} = b;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  initial begin
    vecs[0]  = mk("rebote_shot17_noop", 4'b0010, 5'd17, 1'b0, 1'b0, 8, 6'b001001);
    vecs[1]  = mk("rebote_shot14_noop", 4'b0010, 5'd14, 1'b0, 1'b0, 8, 6'b001001);
    vecs[2]  = mk("rebote_shot9_load14", 4'b0010, 5'd9, 1'b0, 1'b0, 8, 6'b100001);
    vecs[3]  = mk("posse_running_load24", 4'b1000, 5'd9, 1'b0, 1'b0, 8, 6'b101001);
    vecs[4]  = mk("posse_falta_same_cycle", 4'b1100, 5'd5, 1'b0, 1'b0, 8, 6'b101001);
    vecs[5]  = mk("falta_running_stop", 4'b0100, 5'd13, 1'b0, 1'b0, 8, 6'b110000);
    vecs[6]  = mk("pausa_to_running", 4'b0001, 5'd13, 1'b0, 1'b0, 8, 6'b000001);
    vecs[7]  = mk("buzzer_expired", 4'b0000, 5'd0, 1'b0, 1'b1, 1, 6'b010110);
    vecs[8]  = mk("falta_in_expired", 4'b0100, 5'd5, 1'b0, 1'b0, 8, 6'b010110);
    vecs[9]  = mk("posse_clears_violation", 4'b1000, 5'd5, 1'b0, 1'b0, 8, 6'b111000);
    vecs[10] = mk("pausa_run_again", 4'b0001, 5'd20, 1'b0, 1'b0, 8, 6'b001001);
    vecs[11] = mk("game_stop_halts", 4'b0000, 5'd20, 1'b1, 1'b0, 1, 6'b011000);
    vecs[12] = mk("pausa_blocked_by_game_stop", 4'b0001, 5'd20, 1'b1, 1'b0, 8, 6'b011000);
    vecs[13] = mk("rebote_stopped_load14", 4'b0010, 5'd3, 1'b0, 1'b0, 8, 6'b110000);
    vecs[14] = mk("posse_stopped_load24", 4'b1000, 5'd3, 1'b0, 1'b0, 8, 6'b111000);
    vecs[15] = mk("rebote_beats_pausa", 4'b0011, 5'd20, 1'b0, 1'b0, 8, 6'b011000);
    vecs[16] = mk("pausa_final_run", 4'b0001, 5'd20, 1'b0, 1'b0, 8, 6'b001001);

    // Reset and initial load pulse
    repeat (3) @(posedge clock_in);
    #1 check("reset_values", 6'b011000);
    @(negedge clock_in) reset = 1'b0;
    @(posedge clock_in) #1 check("initial_load_pulse", 6'b111000);
    @(posedge clock_in) #1 check("initial_pulse_one_cycle", 6'b011000);

    // Exact debounce latency: event lands 7 edges after the sampling edge
    @(negedge clock_in) drive_btn(4'b0001);
    repeat (7) @(posedge clock_in);
    #1 check("pausa_not_before_latency", 6'b011000);
    @(posedge clock_in) #1 check("pausa_at_latency", 6'b001001);
    @(negedge clock_in) drive_btn(4'b0000);
    idle(10);

    // Three-cycle glitch must be rejected
    @(negedge clock_in) drive_btn(4'b0001);
    idle(3);
    drive_btn(4'b0000);
    idle(12);
    #1 check("pausa_glitch_ignored", 6'b001001);

    for (int i = 0; i < NV; i++) begin
      @(negedge clock_in);
      shot_value  = vecs[i].shot;
      game_stop   = vecs[i].gstop;
      shot_buzzer = vecs[i].buzz;
      drive_btn(vecs[i].btn);
      expect_push(vecs[i].name, vecs[i].exp);
      repeat (vecs[i].edges) @(posedge clock_in);
      #1 check_pop();
      @(negedge clock_in) drive_btn(4'b0000);
      idle(10);
    end

    // Buzzer and posse event on the same edge: reload, no violation
    @(negedge clock_in) drive_btn(4'b1000);
    repeat (7) @(posedge clock_in);
    @(negedge clock_in) shot_buzzer = 1'b1;
    @(posedge clock_in) #1 check("buzzer_with_posse", 6'b101001);
    @(negedge clock_in) begin shot_buzzer = 1'b0; drive_btn(4'b0000); end
    @(posedge clock_in) #1 check("after_buzzer_posse_running", 6'b001001);
    idle(10);

    // A held button gives exactly one reload
    shot_value = 5'd3;
    @(negedge clock_in) drive_btn(4'b0010);
    pulses = 0;
    repeat (40) begin
      @(posedge clock_in) #1;
      if (resetNumero) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL held_rebote_pulses: got %0d expected 1", pulses);
    end
    check("held_rebote_state", 6'b000001);
    @(negedge clock_in) drive_btn(4'b0000);
    idle(10);

    // Reset asserted mid-pulse: immediate reset values, pending work dropped, reload repeats
    shot_value = 5'd20;
    @(negedge clock_in) drive_btn(4'b1000);
    repeat (8) @(posedge clock_in);
    #2 reset = 1'b1;
    #1 check("async_reset_mid_pulse", 6'b011000);
    idle(3);
    drive_btn(4'b0000);
    reset = 1'b0;
    @(posedge clock_in) #1 check("reload_after_reset", 6'b111000);
    pulses = 0;
    repeat (20) begin
      @(posedge clock_in) #1;
      if (resetNumero) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL pending_event_dropped: got %0d pulses expected 0", pulses);
    end
    check("stopped_after_reset", 6'b011000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
